// File: rtl/combi_useq_pkg.sv
// Shared types, instruction field positions and helpers for the LDM/STM micro-sequencer.
package combi_useq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    WB   = 2'b10
  } state_t;

  // Encoded directly as {P,U} so the instruction bits can be cast straight in.
  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } mode_t;

  localparam int P_BIT  = 24;
  localparam int U_BIT  = 23;
  localparam int S_BIT  = 22;
  localparam int W_BIT  = 21;
  localparam int L_BIT  = 20;
  localparam int RN_LO  = 16;

  // Number of set bits in a register list (zero-extended to 32 bits by the caller).
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/combi_lsb_enc.sv
// Lowest-set-bit encoder: index of the least significant 1 and a flag when none is set.
module combi_lsb_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         none
);

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx  = W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/combi_ldstm_seq.sv
// Expands one ARM LDM/STM into single-register load/store micro-ops plus an optional base writeback.
module combi_ldstm_seq #(
  parameter int NREGS  = 16,
  parameter int RIDX   = $clog2(NREGS),
  parameter int WBYTES = 4,
  parameter int OFFW   = $clog2(NREGS * WBYTES) + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            start,
  input  logic            stallD,
  input  logic            flushD,
  output logic            busy,
  output logic            StallFD,
  output logic            uopValid,
  output logic            uopLoad,
  output logic            uopStore,
  output logic            uopWb,
  output logic [RIDX-1:0] uopRd,
  output logic [RIDX-1:0] uopRn,
  output logic [OFFW-1:0] uopOffset,
  output logic            uopLast
);
  import combi_useq_pkg::*;

  localparam int CW = RIDX + 1;
  localparam logic signed [OFFW-1:0] ONE = 1;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic [CW-1:0]    k_q, k_d, n_q, n_d;
  logic             load_q, load_d, wbreq_q, wbreq_d;
  logic [RIDX-1:0]  rn_q, rn_d;

  logic [NREGS-1:0] list, rest;
  logic [RIDX-1:0]  rn_field, cur_idx, unused_rest_idx;
  logic             accept, list_empty, cur_none, rest_none, unused_instr;

  logic signed [OFFW-1:0] k_s, n_s, byte_w, units, xfer_off, wb_off;

  assign list     = instr[NREGS-1:0];
  assign rn_field = instr[RN_LO +: RIDX];
  assign accept   = (state_q == IDLE) && start && !stallD && !flushD;
  // The remaining mask once the current beat's bit is cleared.
  assign rest     = mask_q & (mask_q - NREGS'(1));

  // S and the condition/opcode bits play no part in the expansion.
  assign unused_instr = ^{instr[31:25], instr[S_BIT], cur_none};

  combi_lsb_enc #(.N(NREGS), .W(RIDX)) u_cur_enc (
    .vec  (mask_q),
    .idx  (cur_idx),
    .none (cur_none)
  );

  combi_lsb_enc #(.N(NREGS), .W(RIDX)) u_rest_enc (
    .vec  (rest),
    .idx  (unused_rest_idx),
    .none (rest_none)
  );

  assign list_empty = (list == '0);

  assign k_s    = OFFW'(k_q);
  assign n_s    = OFFW'(n_q);
  assign byte_w = OFFW'(WBYTES);

  // Beat offset in words relative to the original base, by addressing mode.
  always_comb begin
    units = k_s;
    case (mode_q)
      IA: units = k_s;
      IB: units = k_s + ONE;
      DA: units = k_s - n_s + ONE;
      DB: units = k_s - n_s;
      default: units = k_s;
    endcase
  end

  assign xfer_off = units * byte_w;
  assign wb_off   = (mode_q == IA || mode_q == IB) ? (n_s * byte_w) : -(n_s * byte_w);

  // Sequencer state register plus the latched instruction context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= DA;
      mask_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      load_q  <= 1'b0;
      wbreq_q <= 1'b0;
      rn_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      n_q     <= n_d;
      load_q  <= load_d;
      wbreq_q <= wbreq_d;
      rn_q    <= rn_d;
    end
  end

  // Next-state logic: flush beats stall beats advance; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    k_d     = k_q;
    n_d     = n_q;
    load_d  = load_q;
    wbreq_d = wbreq_q;
    rn_d    = rn_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d  = list;
          n_d     = CW'(popcount(32'(list)));
          k_d     = '0;
          mode_d  = mode_t'({instr[P_BIT], instr[U_BIT]});
          load_d  = instr[L_BIT];
          rn_d    = rn_field;
          wbreq_d = instr[W_BIT] && !(instr[L_BIT] && list[rn_field]);
          if (!list_empty) state_d = XFER;
        end
      end
      XFER: begin
        if (flushD) begin
          state_d = IDLE;
          mask_d  = '0;
          k_d     = '0;
        end else if (!stallD) begin
          mask_d = rest;
          k_d    = k_q + CW'(1);
          if (rest_none) state_d = wbreq_q ? WB : IDLE;
        end
      end
      WB: begin
        if (flushD) begin
          state_d = IDLE;
          mask_d  = '0;
          k_d     = '0;
        end else if (!stallD) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Micro-op outputs decoded from registered state; StallFD and the flush override are combinational.
  always_comb begin
    busy      = (state_q != IDLE);
    StallFD   = 1'b0;
    uopValid  = 1'b0;
    uopLoad   = 1'b0;
    uopStore  = 1'b0;
    uopWb     = 1'b0;
    uopRd     = '0;
    uopRn     = '0;
    uopOffset = '0;
    uopLast   = 1'b0;
    case (state_q)
      IDLE: begin
        StallFD = accept && !list_empty && !rst;
      end
      XFER: begin
        uopValid  = !flushD;
        uopLoad   = load_q;
        uopStore  = !load_q;
        uopRd     = cur_idx;
        uopRn     = rn_q;
        uopOffset = xfer_off;
        uopLast   = rest_none && !wbreq_q;
        StallFD   = !uopLast && !flushD;
      end
      WB: begin
        uopValid  = !flushD;
        uopWb     = 1'b1;
        uopRd     = rn_q;
        uopRn     = rn_q;
        uopOffset = wb_off;
        uopLast   = 1'b1;
        StallFD   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_combi_ldstm_seq.sv
// Self-checking bench: directed block transfers plus random ones against an address-level model.
module tb_combi_ldstm_seq;

  localparam int NREGS  = 16;
  localparam int RIDX   = 4;
  localparam int WBYTES = 4;
  localparam int OFFW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr;
  logic            start, stallD, flushD;
  logic            busy, StallFD, uopValid, uopLoad, uopStore, uopWb, uopLast;
  logic [RIDX-1:0] uopRd, uopRn;
  logic [OFFW-1:0] uopOffset;

  typedef struct {
    int rd;
    int off;
    bit load;
    bit wb;
    bit last;
  } beat_t;

  beat_t expq[$];
  int    expRn;
  int    checks = 0;
  int    passes = 0;
  int    fails  = 0;

  combi_ldstm_seq #(.NREGS(NREGS), .RIDX(RIDX), .WBYTES(WBYTES), .OFFW(OFFW)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .start     (start),
    .stallD    (stallD),
    .flushD    (flushD),
    .busy      (busy),
    .StallFD   (StallFD),
    .uopValid  (uopValid),
    .uopLoad   (uopLoad),
    .uopStore  (uopStore),
    .uopWb     (uopWb),
    .uopRd     (uopRd),
    .uopRn     (uopRn),
    .uopOffset (uopOffset),
    .uopLast   (uopLast)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(want), want);
    end
  endtask

  // Builds the expected micro-op list from the ARM block-transfer address rules.
  task automatic buildModel(input logic [31:0] ins);
    logic [15:0] lst;
    int n, j, base0;
    bit p, u, w, l;
    beat_t b;
    lst = ins[15:0];
    p = ins[24]; u = ins[23]; w = ins[21]; l = ins[20];
    expRn = int'(ins[19:16]);
    n = 0;
    for (int r = 0; r < 16; r++) if (lst[r]) n++;
    if (u) base0 = p ? WBYTES : 0;
    else   base0 = p ? -WBYTES * n : -WBYTES * n + WBYTES;
    expq.delete();
    j = 0;
    for (int r = 0; r < 16; r++) begin
      if (lst[r]) begin
        b.rd = r; b.off = base0 + WBYTES * j; b.load = l; b.wb = 0; b.last = 0;
        expq.push_back(b);
        j++;
      end
    end
    if (n != 0 && w && !(l && lst[expRn])) begin
      b.rd = expRn; b.off = u ? WBYTES * n : -WBYTES * n; b.load = 0; b.wb = 1; b.last = 0;
      expq.push_back(b);
    end
    if (expq.size() != 0) expq[expq.size() - 1].last = 1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".uopValid"}, 32'(uopValid), 0);
    checkOutput({tag, ".StallFD"}, 32'(StallFD), 0);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
  endtask

  // abortKind: 0 none, 1 flushD at beat abortAt, 2 rst at beat abortAt.
  task automatic applyStimulus(input logic [31:0] ins, input bit randStall, input int stallAt,
                               input int abortAt, input int abortKind);
    int bIdx, held;
    logic signed [31:0] obsOff;
    beat_t e;
    buildModel(ins);
    @(negedge clk);
    instr = ins; start = 1'b1; stallD = 1'b0; flushD = 1'b0;
    #1;
    checkOutput("accept.StallFD", 32'(StallFD), 32'(expq.size() != 0));
    checkOutput("accept.busy", 32'(busy), 0);
    checkOutput("accept.uopValid", 32'(uopValid), 0);
    bIdx = 0;
    held = 0;
    while (bIdx < expq.size()) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      instr = $urandom;
      if (bIdx == stallAt) stallD = (held < 3);
      else stallD = randStall && held < 2 && ($urandom_range(0, 3) == 0);
      if (bIdx == abortAt && abortKind == 1) begin
        stallD = 1'b0; flushD = 1'b1;
        #1;
        checkOutput("flush.uopValid", 32'(uopValid), 0);
        checkOutput("flush.StallFD", 32'(StallFD), 0);
        @(negedge clk);
        flushD = 1'b0; start = 1'b0;
        #1;
        checkIdle("postflush");
        return;
      end
      if (bIdx == abortAt && abortKind == 2) begin
        stallD = 1'b0; rst = 1'b1;
        #1;
        checkIdle("rst");
        checkOutput("rst.uopRd", 32'(uopRd), 0);
        checkOutput("rst.uopOffset", 32'(uopOffset), 0);
        checkOutput("rst.uopLast", 32'(uopLast), 0);
        checkOutput("rst.uopLoad", 32'(uopLoad), 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        checkIdle("postrst");
        return;
      end
      #1;
      e = expq[bIdx];
      obsOff = 32'($signed(uopOffset));
      checkOutput($sformatf("b%0d.uopValid", bIdx), 32'(uopValid), 1);
      checkOutput($sformatf("b%0d.uopLoad", bIdx), 32'(uopLoad), 32'(e.load));
      checkOutput($sformatf("b%0d.uopStore", bIdx), 32'(uopStore), 32'(!e.wb && !e.load));
      checkOutput($sformatf("b%0d.uopWb", bIdx), 32'(uopWb), 32'(e.wb));
      checkOutput($sformatf("b%0d.uopRd", bIdx), 32'(uopRd), e.rd);
      checkOutput($sformatf("b%0d.uopRn", bIdx), 32'(uopRn), expRn);
      checkOutput($sformatf("b%0d.uopOffset", bIdx), obsOff, e.off);
      checkOutput($sformatf("b%0d.uopLast", bIdx), 32'(uopLast), 32'(e.last));
      checkOutput($sformatf("b%0d.StallFD", bIdx), 32'(StallFD), 32'(!e.last));
      checkOutput($sformatf("b%0d.busy", bIdx), 32'(busy), 1);
      if (stallD) held++;
      else begin
        held = 0;
        bIdx++;
      end
    end
    @(negedge clk);
    start = 1'b0; stallD = 1'b0;
    #1;
    checkIdle("done");
  endtask

  initial begin
    logic [31:0] ins;
    logic [15:0] lst;
    rst = 1'b1; instr = '0; start = 1'b0; stallD = 1'b0; flushD = 1'b0;
    #1;
    checkIdle("reset");
    checkOutput("reset.uopRd", 32'(uopRd), 0);
    checkOutput("reset.uopOffset", 32'(uopOffset), 0);
    #12 rst = 1'b0;

    applyStimulus(32'hE8B0002A, 1'b0, -1, -1, 0);
    applyStimulus(32'hE92D4010, 1'b0, -1, -1, 0);
    applyStimulus(32'hE991FFFF, 1'b0, -1, -1, 0);
    applyStimulus(32'hE8B2000C, 1'b0, -1, -1, 0);
    applyStimulus(32'hE8900000, 1'b0, -1, -1, 0);
    applyStimulus(32'hE8B0002A, 1'b0, 1, -1, 0);
    applyStimulus(32'hE8B0002A, 1'b0, -1, 1, 1);
    applyStimulus(32'hE8B0002A, 1'b0, -1, 1, 2);

    for (int t = 0; t < 80; t++) begin
      ins = $urandom;
      lst = 16'($urandom);
      case ($urandom_range(0, 3))
        0: lst = lst & 16'($urandom) & 16'($urandom);
        1: lst = lst & 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: ;
      endcase
      ins[15:0] = lst;
      applyStimulus(ins, 1'b1, -1, -1, 0);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
